// File: rtl/pu_riscv_ahb_wbuf_drain.sv
// Write-buffer drain engine: pops queued stores and issues them as single
// AHB-Lite write transfers, with wait-state hold and ERROR replay handling.
module pu_riscv_ahb_wbuf_drain #(
   parameter int XLEN  = 64,
   parameter int PLEN  = 64,
   parameter int QBITS = XLEN + PLEN + 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             drain_en_i,
   input  logic             q_empty_i,
   input  logic [QBITS-1:0] q_d_i,
   output logic             q_re_o,
   output logic [PLEN-1:0]  HADDR,
   output logic [XLEN-1:0]  HWDATA,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic [1:0]       HTRANS,
   output logic             HMASTLOCK,
   input  logic             HREADY,
   input  logic             HRESP,
   output logic             err_o,
   output logic [PLEN-1:0]  err_addr_o,
   input  logic             err_clr_i,
   output logic             busy_o
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // Queue entry fields: {hprot, hsize, addr, data}
   logic [XLEN-1:0] q_data;
   logic [PLEN-1:0] q_addr;
   logic [2:0]      q_size;
   logic [3:0]      q_prot;

   assign q_data = q_d_i[XLEN-1:0];
   assign q_addr = q_d_i[XLEN +: PLEN];
   assign q_size = q_d_i[XLEN+PLEN +: 3];
   assign q_prot = q_d_i[XLEN+PLEN+3 +: 4];

   // Address-phase, data-phase and error state
   logic            ap_valid_q, ap_valid_d;
   logic [PLEN-1:0] ap_addr_q,  ap_addr_d;
   logic [XLEN-1:0] ap_data_q,  ap_data_d;
   logic [2:0]      ap_size_q,  ap_size_d;
   logic [3:0]      ap_prot_q,  ap_prot_d;
   logic            ap_cancel_q, ap_cancel_d;
   logic            dp_valid_q, dp_valid_d;
   logic [PLEN-1:0] dp_addr_q,  dp_addr_d;
   logic [XLEN-1:0] hwdata_q,   hwdata_d;
   logic            err_q,      err_d;
   logic [PLEN-1:0] err_addr_q, err_addr_d;

   logic advance;
   logic err_cyc1;
   logic err_cyc2;

   // A pipeline step only happens on a clean HREADY; ERROR's two cycles are
   // told apart by HREADY.
   assign advance  = HREADY & ~HRESP & ~rst_i;
   assign err_cyc1 = HRESP & ~HREADY;
   assign err_cyc2 = HRESP & HREADY;
   assign q_re_o   = advance & drain_en_i & ~q_empty_i;

   // Next-state for the address/data pipeline and the sticky error
   always_comb begin
      ap_valid_d  = ap_valid_q;
      ap_addr_d   = ap_addr_q;
      ap_data_d   = ap_data_q;
      ap_size_d   = ap_size_q;
      ap_prot_d   = ap_prot_q;
      ap_cancel_d = ap_cancel_q;
      dp_valid_d  = dp_valid_q;
      dp_addr_d   = dp_addr_q;
      hwdata_d    = hwdata_q;
      err_d       = err_q;
      err_addr_d  = err_addr_q;

      if (advance) begin
         if (q_re_o) begin
            ap_valid_d = 1'b1;
            ap_addr_d  = q_addr;
            ap_data_d  = q_data;
            ap_size_d  = q_size;
            ap_prot_d  = q_prot;
         end else begin
            ap_valid_d = 1'b0;
         end
         dp_valid_d  = ap_valid_q & ~ap_cancel_q;
         if (ap_valid_q & ~ap_cancel_q) begin
            hwdata_d  = ap_data_q;
            dp_addr_d = ap_addr_q;
         end
         ap_cancel_d = 1'b0;
      end else if (err_cyc1) begin
         // The pending address phase must not be taken; it is replayed later.
         if (dp_valid_q) begin
            ap_cancel_d = 1'b1;
         end
      end else if (err_cyc2) begin
         // Errored store is reported and dropped; ap is kept for replay.
         dp_valid_d  = 1'b0;
         ap_cancel_d = 1'b0;
         err_addr_d  = dp_addr_q;
      end

      if (err_cyc2) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   // State registers; reset abandons any in-flight transfer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ap_valid_q  <= 1'b0;
         ap_addr_q   <= '0;
         ap_data_q   <= '0;
         ap_size_q   <= '0;
         ap_prot_q   <= '0;
         ap_cancel_q <= 1'b0;
         dp_valid_q  <= 1'b0;
         dp_addr_q   <= '0;
         hwdata_q    <= '0;
         err_q       <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         ap_valid_q  <= ap_valid_d;
         ap_addr_q   <= ap_addr_d;
         ap_data_q   <= ap_data_d;
         ap_size_q   <= ap_size_d;
         ap_prot_q   <= ap_prot_d;
         ap_cancel_q <= ap_cancel_d;
         dp_valid_q  <= dp_valid_d;
         dp_addr_q   <= dp_addr_d;
         hwdata_q    <= hwdata_d;
         err_q       <= err_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign HTRANS     = (ap_valid_q & ~ap_cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR      = ap_addr_q;
   assign HSIZE      = ap_size_q;
   assign HPROT      = ap_prot_q;
   assign HWRITE     = ap_valid_q;
   assign HWDATA     = hwdata_q;
   assign HBURST     = 3'b000;
   assign HMASTLOCK  = 1'b0;
   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;
   assign busy_o     = ~q_empty_i | ap_valid_q | dp_valid_q;

endmodule

// File: tb/tb_pu_riscv_ahb_wbuf_drain.sv
// Bench for pu_riscv_ahb_wbuf_drain: directed stimulus with a store queue
// model, a transfer scoreboard and cycle-exact timing checks.
module tb_pu_riscv_ahb_wbuf_drain;

   localparam int XLEN  = 64;
   localparam int PLEN  = 64;
   localparam int QBITS = XLEN + PLEN + 7;

   logic             clk = 1'b0;
   logic             rst_i, drain_en_i, q_empty_i, q_re_o;
   logic [QBITS-1:0] q_d_i;
   logic [PLEN-1:0]  HADDR, err_addr_o;
   logic [XLEN-1:0]  HWDATA;
   logic             HWRITE, HMASTLOCK, HREADY, HRESP, err_o, err_clr_i, busy_o;
   logic [2:0]       HSIZE, HBURST;
   logic [3:0]       HPROT;
   logic [1:0]       HTRANS;

   pu_riscv_ahb_wbuf_drain #(.XLEN(XLEN), .PLEN(PLEN), .QBITS(QBITS)) dut (
      .clk_i(clk), .rst_i(rst_i), .drain_en_i(drain_en_i), .q_empty_i(q_empty_i),
      .q_d_i(q_d_i), .q_re_o(q_re_o), .HADDR(HADDR), .HWDATA(HWDATA),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
      .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [2:0]  size;
      logic [3:0]  prot;
   } xfer_t;

   xfer_t            exp_q[$];
   logic [QBITS-1:0] mem [0:31];
   int               head = 0;
   int               tail = 0;
   int               checks = 0;
   int               failures = 0;
   bit               pend_v = 1'b0;
   logic [63:0]      pend_data;
   xfer_t            mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic update_q();
      q_empty_i = (head == tail);
      q_d_i     = (head < tail) ? mem[head] : '0;
   endtask

   // Load the queue model and record the transfer the bus must carry
   task automatic push(input logic [3:0] prot, input logic [2:0] size,
                       input logic [63:0] addr, input logic [63:0] data);
      xfer_t e;
      mem[tail] = {prot, size, addr, data};
      tail++;
      e.addr = addr; e.data = data; e.size = size; e.prot = prot;
      exp_q.push_back(e);
      update_q();
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Close the cycle; the queue head moves on the same edge as the pop
   task automatic adv();
      logic p;
      p = q_re_o;
      @(posedge clk);
      #1;
      if (p) head++;
      update_q();
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   // Monitor: address phases taken by the slave pop the scoreboard,
   // data phases completing with OKAY must carry the matching write data
   always @(negedge clk) begin
      if (rst_i) begin
         pend_v = 1'b0;
      end else begin
         if (pend_v && HREADY) begin
            if (!HRESP) chk("mon_hwdata", HWDATA, pend_data);
            pend_v = 1'b0;
         end
         if (HTRANS == 2'b10 && HREADY && !HRESP) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL mon_extra_transfer actual=%0h required=none", HADDR);
            end else begin
               mon_e = exp_q.pop_front();
               chk("mon_haddr", HADDR, mon_e.addr);
               chk("mon_hsize", HSIZE, mon_e.size);
               chk("mon_hprot", HPROT, mon_e.prot);
               chk("mon_hwrite", HWRITE, 1);
               pend_v    = 1'b1;
               pend_data = mon_e.data;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] bb_data [0:2];
      bb_data[0] = 64'hA0A0_0000_0000_0001;
      bb_data[1] = 64'hA0A0_0000_0000_0002;
      bb_data[2] = 64'hA0A0_0000_0000_0003;

      rst_i = 1'b1; drain_en_i = 1'b1; HREADY = 1'b1; HRESP = 1'b0; err_clr_i = 1'b0;
      update_q();
      push(4'h1, 3'b010, 64'h80, 64'h1111_2222_3333_4444);

      // Reset with a non-empty queue
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("rst_q_re", q_re_o, 0);
         if (i == 1) begin
            chk("rst_htrans", HTRANS, 0);
            chk("rst_haddr", HADDR, 0);
            chk("rst_hwdata", HWDATA, 0);
            chk("rst_hwrite", HWRITE, 0);
            chk("rst_hsize", HSIZE, 0);
            chk("rst_hprot", HPROT, 0);
            chk("rst_hburst", HBURST, 0);
            chk("rst_hmastlock", HMASTLOCK, 0);
            chk("rst_err", err_o, 0);
            chk("rst_err_addr", err_addr_o, 0);
            chk("rst_busy", busy_o, 1);
         end
         adv();
      end
      rst_i = 1'b0; HREADY = 1'b0;
      settle(); chk("rel_nopop_wait", q_re_o, 0); adv();
      HREADY = 1'b1;
      settle(); chk("rel_first_pop", q_re_o, 1); adv();
      settle(); chk("rel_htrans", HTRANS, 2); chk("rel_haddr", HADDR, 64'h80); adv();
      step(); step();

      // Single write latency
      push(4'h3, 3'b011, 64'h1000, 64'hDEADBEEF_CAFEF00D);
      settle(); chk("sw_pop_c0", q_re_o, 1); adv();
      settle();
      chk("sw_htrans_c1", HTRANS, 2); chk("sw_haddr_c1", HADDR, 64'h1000);
      chk("sw_hsize_c1", HSIZE, 3); chk("sw_hprot_c1", HPROT, 3);
      adv();
      settle(); chk("sw_hwdata_c2", HWDATA, 64'hDEADBEEF_CAFEF00D); chk("sw_idle_c2", HTRANS, 0); adv();
      settle(); chk("sw_busy_c3", busy_o, 0); adv();

      // Back-to-back stream
      for (int k = 0; k < 3; k++) push(4'h3, 3'b011, 64'h100 + 64'(8 * k), bb_data[k]);
      for (int c = 0; c < 6; c++) begin
         settle();
         chk("bb_q_re", q_re_o, (c < 3) ? 1 : 0);
         if (c >= 1 && c <= 3) begin
            chk("bb_htrans", HTRANS, 2);
            chk("bb_haddr", HADDR, 64'h100 + 64'(8 * (c - 1)));
         end
         if (c >= 2 && c <= 4) chk("bb_hwdata", HWDATA, bb_data[c - 2]);
         adv();
      end

      // Wait states during the data phase of 0x100
      push(4'h2, 3'b011, 64'h100, 64'h5555_0000_0000_0100);
      push(4'h2, 3'b011, 64'h108, 64'h5555_0000_0000_0108);
      push(4'h2, 3'b011, 64'h110, 64'h5555_0000_0000_0110);
      step(); step();
      HREADY = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) HREADY = 1'b1;
         settle();
         chk("ws_haddr_hold", HADDR, 64'h108);
         chk("ws_htrans_hold", HTRANS, 2);
         chk("ws_hwdata_hold", HWDATA, 64'h5555_0000_0000_0100);
         chk("ws_q_re", q_re_o, (c == 2) ? 1 : 0);
         adv();
      end
      settle(); chk("ws_haddr_next", HADDR, 64'h110); chk("ws_hwdata_next", HWDATA, 64'h5555_0000_0000_0108); adv();
      settle(); chk("ws_hwdata_last", HWDATA, 64'h5555_0000_0000_0110); adv();
      step();

      // ERROR on 0x2000 with replay of 0x3000
      push(4'h1, 3'b011, 64'h2000, 64'hE000_0000_0000_2000);
      push(4'h1, 3'b011, 64'h3000, 64'hE000_0000_0000_3000);
      push(4'h1, 3'b011, 64'h3008, 64'hE000_0000_0000_3008);
      step(); step();
      HREADY = 1'b0; HRESP = 1'b1;
      settle(); chk("er1_q_re", q_re_o, 0); adv();
      HREADY = 1'b1; HRESP = 1'b1;
      settle();
      chk("er2_htrans_idle", HTRANS, 0);
      chk("er2_q_re", q_re_o, 0);
      chk("er2_err_not_yet", err_o, 0);
      adv();
      HRESP = 1'b0;
      settle();
      chk("er_err_set", err_o, 1);
      chk("er_err_addr", err_addr_o, 64'h2000);
      chk("er_replay_htrans", HTRANS, 2);
      chk("er_replay_haddr", HADDR, 64'h3000);
      chk("er_pop_resume", q_re_o, 1);
      adv();
      settle(); chk("er_replay_hwdata", HWDATA, 64'hE000_0000_0000_3000); chk("er_next_haddr", HADDR, 64'h3008); adv();
      step(); step();
      err_clr_i = 1'b1;
      settle(); chk("clr_err_before", err_o, 1); adv();
      err_clr_i = 1'b0;
      settle(); chk("clr_err_after", err_o, 0); chk("clr_err_addr_kept", err_addr_o, 64'h2000); adv();

      // Drain gate
      push(4'h0, 3'b010, 64'h5000, 64'h0000_0000_6000_5000);
      push(4'h0, 3'b010, 64'h5008, 64'h0000_0000_6000_5008);
      settle(); chk("dg_pop_c0", q_re_o, 1); adv();
      drain_en_i = 1'b0;
      settle(); chk("dg_nopop_c1", q_re_o, 0); chk("dg_inflight_htrans", HTRANS, 2); adv();
      settle(); chk("dg_idle_c2", HTRANS, 0); chk("dg_hwdata_c2", HWDATA, 64'h0000_0000_6000_5000); chk("dg_nopop_c2", q_re_o, 0); adv();
      settle(); chk("dg_idle_c3", HTRANS, 0); chk("dg_nopop_c3", q_re_o, 0); chk("dg_busy_c3", busy_o, 1); adv();
      drain_en_i = 1'b1;
      settle(); chk("dg_pop_resume", q_re_o, 1); adv();
      step(); step();

      // Reset during a data phase
      push(4'h7, 3'b011, 64'h4000, 64'hABCD_0000_0000_4000);
      step(); step();
      rst_i = 1'b1;
      settle(); chk("mr_dp_hwdata", HWDATA, 64'hABCD_0000_0000_4000); adv();
      rst_i = 1'b0;
      settle();
      chk("mr_htrans", HTRANS, 0);
      chk("mr_haddr", HADDR, 0);
      chk("mr_hwdata", HWDATA, 0);
      chk("mr_hwrite", HWRITE, 0);
      chk("mr_hsize", HSIZE, 0);
      chk("mr_hprot", HPROT, 0);
      chk("mr_err_addr", err_addr_o, 0);
      chk("mr_busy", busy_o, 0);
      adv();
      settle(); chk("mr_no_replay", HTRANS, 0); adv();

      chk("end_scoreboard_empty", exp_q.size(), 0);
      chk("end_no_pending_data", pend_v, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
